lab1_spart: RTL and testbench

LAB1_SPART -- requirements
Module: lab1_spart

---
 rtl/lab1_spart.sv | 215 +++++++++++++++++++++
 tb/tb_lab1_spart.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_spart.sv
// lab1_spart: serial port that echoes each byte received on GPIO[5] back out on GPIO[3].
// The last byte echoed is shown on LEDR; the baud rate is selected live from SW[9:8].
module lab1_spart #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLOCK_50,
  input  logic        CLOCK2_50,
  input  logic        CLOCK3_50,
  input  logic        CLOCK4_50,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  inout  wire  [35:0] GPIO,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    int baud;
    case (sel)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    // Nearest whole number of clocks per tick, minus one for the counter's zero state.
    return 16'((CLK_FREQ + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud) - 1);
  endfunction

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [15:0] div_sel;
  logic [15:0] div_r;

  assign clk     = CLOCK_50;
  assign rst_n   = KEY[0];
  assign rxd     = GPIO[5];
  assign div_sel = div_of(SW[9:8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_r <= div_sel;
    else        div_r <= div_sel;
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rxd_p0, rxd_p1, rxd_p2;
  logic [15:0]   rx_cnt;
  logic [TW-1:0] rx_ticks;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_data;
  logic          rda;
  logic          rx_tick;

  logic          txd;
  logic          tbr;
  logic          tx_busy;
  logic [15:0]   tx_cnt;
  logic [TW-1:0] tx_ticks;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_tick;
  logic          tx_last;

  logic          rd;
  logic [7:0]    led_byte;

  assign rx_tick = (rx_cnt == 16'd0);
  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_last = tx_busy && (tx_bit == 4'd9) && (tx_ticks == LAST);
  assign rd      = rda & tbr;

  // Receive: rxd_p0/rxd_p1 synchronize, rxd_p2 holds the previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      rxd_p2   <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= div_sel;
      rx_ticks <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rda      <= 1'b0;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
      rx_cnt <= rx_tick ? div_r : rx_cnt - 16'd1;
      if (rd) rda <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_p2 && !rxd_p1) begin
            rx_state <= RX_START;
            rx_cnt   <= div_r;
            rx_ticks <= '0;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_ticks == HALF) begin
              rx_ticks <= '0;
              rx_bit   <= '0;
              rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
            end else begin
              rx_ticks <= rx_ticks + TW'(1);
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            if (rx_ticks == LAST) begin
              rx_ticks <= '0;
              rx_shift <= {rxd_p1, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end else begin
              rx_ticks <= rx_ticks + TW'(1);
            end
          end
        end
        default: begin
          if (rx_tick) begin
            if (rx_ticks == LAST) begin
              rx_ticks <= '0;
              rx_state <= RX_IDLE;
              // A low stop bit is a framing error: drop the byte, leave RDA alone.
              if (rxd_p1) begin
                rx_data <= rx_shift;
                rda     <= 1'b1;
              end
            end else begin
              rx_ticks <= rx_ticks + TW'(1);
            end
          end
        end
      endcase
    end
  end

  // Transmit: the baud counter restarts on acceptance so the start bit is a full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd      <= 1'b1;
      tbr      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= div_sel;
      tx_ticks <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (rd) begin
      txd      <= 1'b0;
      tbr      <= 1'b0;
      tx_busy  <= 1'b1;
      tx_cnt   <= div_r;
      tx_ticks <= '0;
      tx_bit   <= '0;
      tx_shift <= {1'b1, rx_data};
    end else if (tx_busy) begin
      tx_cnt <= tx_tick ? div_r : tx_cnt - 16'd1;
      // TBR rises one clock early so a waiting byte starts exactly as the stop bit ends.
      if (tx_last && (tx_cnt == 16'd1 || tx_tick)) tbr <= 1'b1;
      if (tx_tick) begin
        if (tx_ticks == LAST) begin
          tx_ticks <= '0;
          if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bit   <= tx_bit + 4'd1;
          end
        end else begin
          tx_ticks <= tx_ticks + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  led_byte <= '0;
    else if (rd) led_byte <= rx_data;
  end

  assign LEDR = {tbr, rda, led_byte};
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;

  assign GPIO[2:0]  = 3'bzzz;
  assign GPIO[3]    = txd;
  assign GPIO[4]    = 1'bz;
  assign GPIO[35:6] = {30{1'bz}};

  logic unused_ok;
  assign unused_ok = &{1'b0, CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1], SW[7:0],
                       GPIO[35:6], GPIO[4:0]};

endmodule

// File: tb/tb_lab1_spart.sv
// Bench for lab1_spart: drives serial frames into RXD and scoreboards the echoed TXD frames.
module tb_lab1_spart;

  logic        clk = 1'b0;
  logic        c2 = 1'b0, c3 = 1'b0, c4 = 1'b0;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic        rxd;
  wire  [35:0] gpio;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        txd_w;

  always #10 clk = ~clk;

  assign gpio[5] = rxd;
  assign txd_w   = gpio[3];

  logic unused_gpio;
  assign unused_gpio = ^{gpio[35:6], gpio[4], gpio[2:0]};

  lab1_spart dut (
    .CLOCK_50(clk), .CLOCK2_50(c2), .CLOCK3_50(c3), .CLOCK4_50(c4),
    .KEY(key), .SW(sw), .GPIO(gpio), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         bit_p;
  logic [7:0] exp_q[$];
  bit         mon_busy = 1'b0;
  bit         mon_en = 1'b0;

  // Clocks per bit from the baud table: 16 ticks of DIV+1 clocks.
  function automatic int period(input logic [1:0] s);
    int d;
    case (s)
      2'b00:   d = 650;
      2'b01:   d = 325;
      2'b10:   d = 162;
      default: d = 80;
    endcase
    return 16 * (d + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (bit_p) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || mon_busy) && i < 30000) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(exp_q.size()) + 64'(mon_busy), 64'd0);
  endtask

  // Monitor: every TXD frame must match the next expected byte, clock by clock.
  initial begin : monitor
    logic       prev;
    logic [9:0] f;
    logic [7:0] got, expb;
    int         bad, p;
    bit         have, aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && key[0] && prev === 1'b1 && txd_w === 1'b0) begin
        mon_busy = 1'b1;
        p = bit_p;
        have = (exp_q.size() != 0);
        expb = have ? exp_q.pop_front() : 8'h00;
        f = {1'b1, expb, 1'b0};
        bad = 0;
        got = '0;
        aborted = 1'b0;
        for (int c = 0; c < 10 * p; c++) begin
          if (c != 0) @(negedge clk);
          if (!key[0]) begin
            aborted = 1'b1;
            break;
          end
          if (txd_w !== f[c / p]) bad++;
          if ((c % p) == p / 2 && c / p >= 1 && c / p <= 8) got[c / p - 1] = txd_w;
        end
        if (!aborted) begin
          if (!have) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_echo: TXD frame carrying %02h, required no frame", got);
          end else begin
            check("echo_byte", 64'(got), 64'(expb));
            check("echo_bit_timing_errors", 64'(bad), 64'd0);
          end
        end
        mon_busy = 1'b0;
      end
      prev = txd_w;
    end
  end

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         edges;
    logic       prev;
    bit         rda_seen;
    bit         found;
    int         i;
    logic [7:0] bad_b, r;

    key = 4'hF;
    sw = 10'h100;
    rxd = 1'b1;
    bit_p = period(2'b01);
    @(negedge clk);
    key[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_txd", 64'(txd_w), 64'd1);
    check("reset_ledr", 64'(ledr), 64'h200);
    check("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
    key[0] = 1'b1;
    mon_en = 1'b1;

    edges = 0;
    prev = txd_w;
    repeat (2000) begin
      @(negedge clk);
      if (txd_w !== prev) edges++;
      prev = txd_w;
    end
    check("idle_txd_edges", 64'(edges), 64'd0);
    check("idle_ledr", 64'(ledr), 64'h200);

    // 1000-clock low pulse at 9600 baud is a glitch, not a start bit.
    rxd = 1'b0;
    repeat (1000) @(negedge clk);
    rxd = 1'b1;
    rda_seen = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      if (ledr[8]) rda_seen = 1'b1;
    end
    check("glitch_rda", 64'(rda_seen), 64'd0);
    check("glitch_data", 64'(ledr[7:0]), 64'd0);

    sw = 10'h300;
    bit_p = period(2'b11);
    repeat (700) @(negedge clk);

    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    check("ledr_a3", 64'(ledr[7:0]), 64'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    check("ledr_0f", 64'(ledr[7:0]), 64'h0F);

    bad_b = 8'($urandom);
    send_frame(bad_b, 1'b0);
    repeat (bit_p) @(negedge clk);
    check("framing_rda", 64'(ledr[8]), 64'd0);
    check("framing_data", 64'(ledr[7:0]), 64'h0F);
    wait_drain("drain_back_to_back");

    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    found = 1'b0;
    i = 0;
    while (!found && i < 3 * bit_p) begin
      if (txd_w === 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    check("ff_echo_started", 64'(found), 64'd1);
    repeat ($urandom_range(20, 400)) @(negedge clk);
    key[0] = 1'b0;
    #1;
    check("abort_txd", 64'(txd_w), 64'd1);
    check("abort_tbr_rda", 64'(ledr[9:8]), 64'h2);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("abort_ledr", 64'(ledr), 64'h200);
    key[0] = 1'b1;

    r = 8'($urandom);
    exp_q.push_back(r);
    send_frame(r, 1'b1);
    check("ledr_after_reset", 64'(ledr[7:0]), 64'(r));
    wait_drain("drain_after_reset");
    check("final_rda", 64'(ledr[8]), 64'd0);
    check("final_tbr", 64'(ledr[9]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
